// File: rtl/seq_decrypt_if.sv
// Handshake/data bundle between the packet source and seq_decrypt.
// The master drives the cipher stream and config; the slave reports the plain bytes.
interface seq_decrypt_if #(
   parameter int DW   = 8,
   parameter int LW   = 5,
   parameter int CNTW = 8
);
   logic            cfgLoad;
   logic [CNTW-1:0] preLen;
   logic [LW-1:0]   taps;
   logic [LW-1:0]   seed;
   logic            validIn;
   logic [DW-1:0]   cipherByte;
   logic            pktEnd;
   logic [DW-1:0]   plainByte;
   logic            validOut;
   logic            preambleErr;
   logic            fmtErr;
   logic [CNTW-1:0] payCount;
   logic            done;
   logic            busy;

   modport master (
      output cfgLoad, preLen, taps, seed,
      output validIn, cipherByte, pktEnd,
      input  plainByte, validOut,
      input  preambleErr, fmtErr, payCount,
      input  done, busy
   );

   modport slave (
      input  cfgLoad, preLen, taps, seed,
      input  validIn, cipherByte, pktEnd,
      output plainByte, validOut,
      output preambleErr, fmtErr, payCount,
      output done, busy
   );
endinterface

// File: rtl/seq_decrypt.sv
// LFSR stream decryptor: checks the preamble of an encrypted packet
// and recovers 7-bit ASCII payload bytes with one cycle of latency.
module seq_decrypt #(
   parameter int DW   = 8,
   parameter int LW   = 5,
   parameter int CNTW = 8
) (
   input logic          clk,
   input logic          rst,
   seq_decrypt_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      PREAMBLE,
      PAYLOAD,
      DONE
   } stateT;

   localparam logic [DW-1:0]   PRE_BYTE   = DW'(8'h7E);
   localparam logic [DW-1:0]   ASCII_MASK = {1'b0, {(DW-1){1'b1}}};
   localparam logic [CNTW-1:0] CNT_MAX    = '1;

   stateT           state;
   stateT           stateNext;
   logic [LW-1:0]   lfsr;
   logic [LW-1:0]   tapsR;
   logic [LW-1:0]   lfsrStep;
   logic [CNTW-1:0] preLenR;
   logic [CNTW-1:0] preCnt;
   logic [CNTW-1:0] payCount;
   logic [DW-1:0]   key;
   logic [DW-1:0]   plainByte;
   logic            validOut;
   logic            preambleErr;
   logic            fmtErr;
   logic            loadCfg;
   logic            acceptPre;
   logic            acceptPay;
   logic            preLast;
   logic            preMiss;
   logic            truncated;

   assign key      = {{(DW-LW){1'b0}}, lfsr};
   assign lfsrStep = {lfsr[LW-2:0], ^(lfsr & tapsR)};
   assign preLast  = (preCnt == preLenR - CNTW'(1));
   assign preMiss  = (bus.cipherByte != (PRE_BYTE ^ key));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // pktEnd wins over the preamble->payload hop: a packet that ends
   // on its last preamble byte is still a truncated packet.
   always_comb begin
      stateNext = state;
      loadCfg   = 1'b0;
      acceptPre = 1'b0;
      acceptPay = 1'b0;
      truncated = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.cfgLoad) begin
               loadCfg = 1'b1;
               if (bus.preLen != '0) begin
                  stateNext = PREAMBLE;
               end else begin
                  stateNext = PAYLOAD;
               end
            end
         end
         PREAMBLE: begin
            acceptPre = bus.validIn;
            if (bus.pktEnd) begin
               truncated = 1'b1;
               stateNext = DONE;
            end else if (bus.validIn && preLast) begin
               stateNext = PAYLOAD;
            end
         end
         PAYLOAD: begin
            acceptPay = bus.validIn;
            if (bus.pktEnd) begin
               stateNext = DONE;
            end
         end
         DONE: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr        <= '0;
         tapsR       <= '0;
         preLenR     <= '0;
         preCnt      <= '0;
         payCount    <= '0;
         plainByte   <= '0;
         validOut    <= 1'b0;
         preambleErr <= 1'b0;
         fmtErr      <= 1'b0;
      end else begin
         validOut <= acceptPay;
         if (loadCfg) begin
            preLenR     <= bus.preLen;
            tapsR       <= bus.taps;
            lfsr        <= bus.seed;
            preCnt      <= '0;
            payCount    <= '0;
            preambleErr <= 1'b0;
            fmtErr      <= 1'b0;
         end
         if (acceptPre || acceptPay) begin
            lfsr <= lfsrStep;
         end
         if (acceptPre) begin
            preCnt <= preCnt + CNTW'(1);
            if (preMiss) begin
               preambleErr <= 1'b1;
            end
         end
         if (truncated) begin
            preambleErr <= 1'b1;
         end
         if (acceptPay) begin
            plainByte <= (bus.cipherByte ^ key) & ASCII_MASK;
            if (!bus.cipherByte[DW-1]) begin
               fmtErr <= 1'b1;
            end
            if (payCount != CNT_MAX) begin
               payCount <= payCount + CNTW'(1);
            end
         end
      end
   end

   assign bus.plainByte   = plainByte;
   assign bus.validOut    = validOut;
   assign bus.preambleErr = preambleErr;
   assign bus.fmtErr      = fmtErr;
   assign bus.payCount    = payCount;
   assign bus.done        = (state == DONE);
   assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_seq_decrypt.sv
// Scoreboard bench for seq_decrypt: directed packets push expected
// plain bytes and done summaries; a negedge monitor pops and compares.
module tb_seq_decrypt;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } plainT;

   typedef struct {
      logic [7:0] cnt;
      logic       pe;
      logic       fe;
      int         cyc;
   } doneT;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   plainT plainQ[$];
   doneT  doneQ[$];

   seq_decrypt_if #(.DW(8), .LW(5), .CNTW(8)) bus ();

   seq_decrypt dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.validOut) begin
            if (plainQ.size() == 0) begin
               chk("spuriousValidOut", 32'(bus.validOut), 32'd0);
            end else begin
               plainT p;
               p = plainQ.pop_front();
               chk("plainByte", 32'(bus.plainByte), 32'(p.data));
               chk("plainLatency", cyc, p.cyc);
            end
         end
         if (bus.done) begin
            if (doneQ.size() == 0) begin
               chk("spuriousDone", 32'(bus.done), 32'd0);
            end else begin
               doneT d;
               d = doneQ.pop_front();
               chk("payCount", 32'(bus.payCount), 32'(d.cnt));
               chk("preambleErr", 32'(bus.preambleErr), 32'(d.pe));
               chk("fmtErr", 32'(bus.fmtErr), 32'(d.fe));
               chk("doneCyc", cyc, d.cyc);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic [7:0] pl, input logic [4:0] tp,
                      input logic [4:0] sd);
      bus.cfgLoad = 1'b1;
      bus.preLen  = pl;
      bus.taps    = tp;
      bus.seed    = sd;
      tick();
      bus.cfgLoad = 1'b0;
   endtask

   task automatic pre(input logic [7:0] b);
      bus.validIn    = 1'b1;
      bus.cipherByte = b;
      tick();
      bus.validIn = 1'b0;
   endtask

   task automatic pay(input logic [7:0] b, input logic [7:0] exp,
                      input logic last);
      plainT p;
      p.data = exp;
      p.cyc  = cyc + 1;
      plainQ.push_back(p);
      bus.validIn    = 1'b1;
      bus.cipherByte = b;
      bus.pktEnd     = last;
      tick();
      bus.validIn = 1'b0;
      bus.pktEnd  = 1'b0;
   endtask

   task automatic pushDone(input logic [7:0] cnt, input logic pe,
                           input logic fe);
      doneT d;
      d.cnt = cnt;
      d.pe  = pe;
      d.fe  = fe;
      d.cyc = cyc + 1;
      doneQ.push_back(d);
   endtask

   task automatic endPkt(input logic [7:0] cnt, input logic pe,
                         input logic fe);
      pushDone(cnt, pe, fe);
      bus.pktEnd = 1'b1;
      tick();
      bus.pktEnd = 1'b0;
      tick();
      tick();
   endtask

   task automatic chkIdleZero(input string tag);
      chk({tag, "_validOut"}, 32'(bus.validOut), 32'd0);
      chk({tag, "_plainByte"}, 32'(bus.plainByte), 32'd0);
      chk({tag, "_payCount"}, 32'(bus.payCount), 32'd0);
      chk({tag, "_preambleErr"}, 32'(bus.preambleErr), 32'd0);
      chk({tag, "_fmtErr"}, 32'(bus.fmtErr), 32'd0);
      chk({tag, "_done"}, 32'(bus.done), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      bus.cfgLoad    = 1'b0;
      bus.preLen     = '0;
      bus.taps       = '0;
      bus.seed       = '0;
      bus.validIn    = 1'b0;
      bus.cipherByte = '0;
      bus.pktEnd     = 1'b0;
      tick();
      tick();
      chkIdleZero("reset");
      rst = 1'b0;
      tick();

      // T1: clean packet
      cfg(8'd2, 5'b10100, 5'b00001);
      chk("busyAfterCfg", 32'(bus.busy), 32'd1);
      pre(8'h7F);
      pre(8'h7C);
      pay(8'hC5, 8'h41, 1'b0);
      pay(8'hCB, 8'h42, 1'b0);
      endPkt(8'd2, 1'b0, 1'b0);
      chk("t1IdleBusy", 32'(bus.busy), 32'd0);

      // T2: corrupt second preamble byte
      cfg(8'd2, 5'b10100, 5'b00001);
      pre(8'h7F);
      pre(8'h7D);
      pay(8'hC5, 8'h41, 1'b0);
      pay(8'hCB, 8'h42, 1'b0);
      endPkt(8'd2, 1'b1, 1'b0);
      chk("t2PeHold", 32'(bus.preambleErr), 32'd1);

      // T3: no preamble
      cfg(8'd0, 5'b10100, 5'b00001);
      pay(8'hC1, 8'h40, 1'b0);
      endPkt(8'd1, 1'b0, 1'b0);

      // T4: payload byte with bit7 clear
      cfg(8'd2, 5'b10100, 5'b00001);
      pre(8'h7F);
      pre(8'h7C);
      pay(8'h45, 8'h41, 1'b0);
      endPkt(8'd1, 1'b0, 1'b1);
      chk("t4FeHold", 32'(bus.fmtErr), 32'd1);

      // T5: cfgLoad mid-payload ignored, byte and pktEnd together
      cfg(8'd2, 5'b10100, 5'b00001);
      pre(8'h7F);
      pre(8'h7C);
      pay(8'hC5, 8'h41, 1'b0);
      cfg(8'd0, 5'b11111, 5'b11111);
      pushDone(8'd2, 1'b0, 1'b0);
      pay(8'hCB, 8'h42, 1'b1);
      tick();
      tick();

      // truncated preamble
      cfg(8'd2, 5'b10100, 5'b00001);
      pre(8'h7F);
      endPkt(8'd0, 1'b1, 1'b0);

      // zero seed: key stays 0
      cfg(8'd0, 5'b10100, 5'b00000);
      pay(8'h85, 8'h05, 1'b0);
      pay(8'h86, 8'h06, 1'b0);
      endPkt(8'd2, 1'b0, 1'b0);

      // payCount saturation
      cfg(8'd0, 5'b10100, 5'b00000);
      for (int i = 0; i < 257; i++) begin
         pay(8'h80, 8'h00, 1'b0);
      end
      endPkt(8'd255, 1'b0, 1'b0);

      // T6: async reset mid-payload
      cfg(8'd2, 5'b10100, 5'b00001);
      pre(8'h7F);
      pre(8'h7C);
      pay(8'hC5, 8'h41, 1'b0);
      bus.validIn    = 1'b1;
      bus.cipherByte = 8'hCB;
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      bus.validIn = 1'b0;
      chkIdleZero("t6Rst");
      tick();
      rst = 1'b0;
      tick();
      chkIdleZero("t6Post");
      cfg(8'd0, 5'b10100, 5'b00001);
      pay(8'hC1, 8'h40, 1'b0);
      endPkt(8'd1, 1'b0, 1'b0);

      tick();
      tick();
      chk("plainQEmpty", plainQ.size(), 32'd0);
      chk("doneQEmpty", doneQ.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
